keypad_encoder: RTL

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_encoder.sv
// keypad_encoder: 4x4 matrix keypad scanner with debounce and single-strobe key reporting.
// Build option KEYPAD_REPEAT_EN adds auto-repeat strobes while a key stays held.
module keypad_encoder #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE_CYC = 8,
  parameter int unsigned REPEAT_CYC   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  input  logic       accept,
  output logic [3:0] key_col,
  output logic [3:0] keypad_data,
  output logic       keypad_enable,
  output logic       key_held
);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] HOLD     = 2'd3;

  localparam int unsigned DIV_W = $clog2(SCAN_DIV + 1);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

  logic [3:0]       r_sync1, r_sync2;
  logic [1:0]       r_state, w_state_next;
  logic [1:0]       r_col_idx, w_col_idx_next;
  logic [1:0]       r_row_idx, w_row_idx_next;
  logic [DIV_W-1:0] r_div_cnt, w_div_cnt_next;
  logic [DEB_W-1:0] r_deb_cnt, w_deb_cnt_next;
  logic [3:0]       r_data, w_data_next;
  logic             r_enable, w_enable_next;
  logic             r_held, w_held_next;

  logic             w_row_bit;
  logic             w_any_low;
  logic [1:0]       w_low_row;
  logic [3:0]       w_code;
  logic             w_rep_fire;

  assign w_row_bit = r_sync2[r_row_idx];
  assign w_any_low = ~&r_sync2;
  assign w_code    = {r_row_idx, r_col_idx};

  // Lowest-numbered low row wins when several rows are active.
  always_comb begin
    w_low_row = 2'd3;
    if (!r_sync2[0])      w_low_row = 2'd0;
    else if (!r_sync2[1]) w_low_row = 2'd1;
    else if (!r_sync2[2]) w_low_row = 2'd2;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYC + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_next;

  assign w_rep_fire = (r_state == HOLD) && !w_row_bit && (r_rep_cnt == REP_LAST);

  always_comb begin
    w_rep_cnt_next = '0;
    if (r_state == HOLD && !w_row_bit && !w_rep_fire) w_rep_cnt_next = r_rep_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rep_cnt <= '0;
    else        r_rep_cnt <= w_rep_cnt_next;
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_col_idx_next = r_col_idx;
    w_row_idx_next = r_row_idx;
    w_div_cnt_next = r_div_cnt;
    w_deb_cnt_next = r_deb_cnt;
    w_data_next    = r_data;
    w_enable_next  = 1'b0;
    w_held_next    = r_held;
    case (r_state)
      SCAN: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_cnt_next = '0;
          if (w_any_low) begin
            w_row_idx_next = w_low_row;
            w_deb_cnt_next = '0;
            w_state_next   = DEBOUNCE;
          end else begin
            w_col_idx_next = r_col_idx + 2'd1;
          end
        end else begin
          w_div_cnt_next = r_div_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (w_row_bit) begin
          w_state_next   = SCAN;
          w_col_idx_next = r_col_idx + 2'd1;
          w_div_cnt_next = '0;
          w_deb_cnt_next = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_next   = PRESSED;
          w_deb_cnt_next = '0;
        end else begin
          w_deb_cnt_next = r_deb_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (accept) begin
          w_data_next   = w_code;
          w_enable_next = 1'b1;
        end
        w_held_next    = 1'b1;
        w_deb_cnt_next = '0;
        w_state_next   = HOLD;
      end
      HOLD: begin
        if (w_row_bit) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_held_next    = 1'b0;
            w_state_next   = SCAN;
            w_col_idx_next = r_col_idx + 2'd1;
            w_div_cnt_next = '0;
            w_deb_cnt_next = '0;
          end else begin
            w_deb_cnt_next = r_deb_cnt + 1'b1;
          end
        end else begin
          w_deb_cnt_next = '0;
        end
        if (w_rep_fire && accept) begin
          w_data_next   = w_code;
          w_enable_next = 1'b1;
        end
      end
      default: w_state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_state   <= SCAN;
      r_col_idx <= '0;
      r_row_idx <= '0;
      r_div_cnt <= '0;
      r_deb_cnt <= '0;
      r_data    <= '0;
      r_enable  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_sync1   <= key_row;
      r_sync2   <= r_sync1;
      r_state   <= w_state_next;
      r_col_idx <= w_col_idx_next;
      r_row_idx <= w_row_idx_next;
      r_div_cnt <= w_div_cnt_next;
      r_deb_cnt <= w_deb_cnt_next;
      r_data    <= w_data_next;
      r_enable  <= w_enable_next;
      r_held    <= w_held_next;
    end
  end

  // Column drive is a pure decode of the index, so it freezes whenever the index does.
  always_comb begin
    key_col            = 4'b1111;
    key_col[r_col_idx] = 1'b0;
  end

  assign keypad_data   = r_data;
  assign keypad_enable = r_enable;
  assign key_held      = r_held;

endmodule
